regfile_write_arbiter: RTL and testbench

//  Shares the single register-file write port between the in-order writeback stage and a

---
 rtl/regfile_write_arbiter_pkg.sv | 26 ++
 rtl/regfile_write_arbiter_pending_fifo.sv | 141 ++++++++++++++
 rtl/regfile_write_arbiter.sv | 125 ++++++++++++
 tb/tb_regfile_write_arbiter.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_write_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// regfile_write_arbiter_pkg
// Shared core definitions used by the register-file write arbiter:
//   REGISTER_WIDTH / REGISTER_DEPTH  register file geometry
//   REG_ADDR_W                       register address width
//   reg_write_t                      one register-file write {address, data}
//   rd_hit()                         address compare that never matches x0
// -----------------------------------------------------------------------------
package regfile_write_arbiter_pkg;

    localparam int REGISTER_WIDTH = 32;
    localparam int REGISTER_DEPTH = 32;
    localparam int REG_ADDR_W     = $clog2(REGISTER_DEPTH);

    typedef struct packed {
        logic [REG_ADDR_W-1:0]     address;
        logic [REGISTER_WIDTH-1:0] data;
    } reg_write_t;

    // x0 is hard-wired zero, so it never creates a dependency
    function automatic logic rd_hit(input logic [REG_ADDR_W-1:0] a,
                                    input logic [REG_ADDR_W-1:0] b);
        return (a == b) && (a != {REG_ADDR_W{1'b0}});
    endfunction

endpackage

// File: rtl/regfile_write_arbiter_pending_fifo.sv
// -----------------------------------------------------------------------------
// regwr_pending_fifo
// Small FIFO of MDU results waiting for an idle register-file write cycle.
// Each slot carries a squash bit: a younger writeback to the same rd makes
// the queued result stale, but the slot is kept until it reaches the head.
// Ports:
//   clk, rst                      clock, asynchronous active-low reset
//   push, push_entry              enqueue one result (caller guarantees !full)
//   pop                           drop the head (caller guarantees !empty)
//   squash_en, squash_address     mark all entries (incl. one pushed now) with rd
//   head_entry, head_live         oldest entry and whether it is still live
//   empty, full, count            occupancy (count is registered)
//   rs1_address/rs2_address, rs1_hit/rs2_hit   live-entry lookup, only when
//                                 REGWR_ARB_HAZARD_EN is defined
// -----------------------------------------------------------------------------
module regwr_pending_fifo
    import regfile_write_arbiter_pkg::*;
#(
    parameter  int FIFO_DEPTH = 4,
    localparam int PTR_W      = $clog2(FIFO_DEPTH),
    localparam int CNT_W      = $clog2(FIFO_DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  reg_write_t            push_entry,
    input  logic                  pop,
    input  logic                  squash_en,
    input  logic [REG_ADDR_W-1:0] squash_address,
`ifdef REGWR_ARB_HAZARD_EN
    input  logic [REG_ADDR_W-1:0] rs1_address,
    input  logic [REG_ADDR_W-1:0] rs2_address,
    output logic                  rs1_hit,
    output logic                  rs2_hit,
`endif
    output reg_write_t            head_entry,
    output logic                  head_live,
    output logic                  empty,
    output logic                  full,
    output logic [CNT_W-1:0]      count
);

    localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(FIFO_DEPTH);

    reg_write_t              entry_r [FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0]   valid_r;
    logic [FIFO_DEPTH-1:0]   squash_r;
    logic [PTR_W-1:0]        rd_ptr_r;
    logic [PTR_W-1:0]        wr_ptr_r;
    logic [CNT_W-1:0]        count_r;
    logic [CNT_W-1:0]        count_next_s;
    logic [FIFO_DEPTH-1:0]   squash_match_s;
    logic                    push_squash_s;

    assign head_entry = entry_r[rd_ptr_r];
    assign head_live  = ~squash_r[rd_ptr_r];
    assign empty      = (count_r == {CNT_W{1'b0}});
    assign full       = (count_r == CNT_MAX);
    assign count      = count_r;

    // a result pushed in the same cycle as a matching writeback is already stale
    assign push_squash_s = squash_en && (push_entry.address == squash_address);

    // occupied slots whose rd matches the current writeback rd
    always_comb begin
        squash_match_s = {FIFO_DEPTH{1'b0}};
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            if (squash_en && valid_r[i] && (entry_r[i].address == squash_address)) begin
                squash_match_s[i] = 1'b1;
            end else begin
                squash_match_s[i] = 1'b0;
            end
        end
    end

    // occupancy after this cycle's push/pop
    always_comb begin
        count_next_s = count_r;
        case ({push, pop})
            2'b10:   count_next_s = count_r + CNT_ONE;
            2'b01:   count_next_s = count_r - CNT_ONE;
            default: count_next_s = count_r;
        endcase
    end

    // storage, pointers, squash bits and count
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                entry_r[i] <= '0;
            end
            valid_r  <= {FIFO_DEPTH{1'b0}};
            squash_r <= {FIFO_DEPTH{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            wr_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
        end else begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                if (squash_match_s[i]) begin
                    squash_r[i] <= 1'b1;
                end
            end
            if (pop) begin
                valid_r[rd_ptr_r]  <= 1'b0;
                squash_r[rd_ptr_r] <= 1'b0;
                rd_ptr_r           <= rd_ptr_r + PTR_ONE;
            end
            // the push slot is never the popped slot: push is blocked when full
            if (push) begin
                entry_r[wr_ptr_r]  <= push_entry;
                valid_r[wr_ptr_r]  <= 1'b1;
                squash_r[wr_ptr_r] <= push_squash_s;
                wr_ptr_r           <= wr_ptr_r + PTR_ONE;
            end
            count_r <= count_next_s;
        end
    end

`ifdef REGWR_ARB_HAZARD_EN
    // live queued results targeting the source registers being read
    always_comb begin
        rs1_hit = 1'b0;
        rs2_hit = 1'b0;
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            if (valid_r[i] && !squash_r[i] && rd_hit(entry_r[i].address, rs1_address)) begin
                rs1_hit = 1'b1;
            end else begin
                rs1_hit = rs1_hit;
            end
            if (valid_r[i] && !squash_r[i] && rd_hit(entry_r[i].address, rs2_address)) begin
                rs2_hit = 1'b1;
            end else begin
                rs2_hit = rs2_hit;
            end
        end
    end
`endif

endmodule

// File: rtl/regfile_write_arbiter.sv
// -----------------------------------------------------------------------------
// regfile_write_arbiter
// Shares the register-file write port between writeback (always wins, cannot
// stall) and the MDU (results queued, drained on idle writeback cycles).
// Optional feature macro: REGWR_ARB_HAZARD_EN adds rs1/rs2 pending lookups.
// Ports:
//   clk, rst                         clock, asynchronous active-low reset
//   wb_enable/wb_address/wb_data     writeback write request
//   mdu_tvalid/mdu_tready            MDU result handshake
//   mdu_address/mdu_data             MDU result
//   rf_enable/rf_address/rf_data     register-file write port (combinational)
//   bubble_req                       ask issue for a writeback-free cycle
//   pending_count                    queued entries, live + squashed (registered)
//   rs1_address/rs2_address, rs1_pending/rs2_pending  (REGWR_ARB_HAZARD_EN only)
// -----------------------------------------------------------------------------
module regfile_write_arbiter
    import regfile_write_arbiter_pkg::*;
#(
    parameter int FIFO_DEPTH   = 4,
    parameter int STARVE_LIMIT = 8
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             wb_enable,
    input  logic [REG_ADDR_W-1:0]            wb_address,
    input  logic [REGISTER_WIDTH-1:0]        wb_data,
    input  logic                             mdu_tvalid,
    output logic                             mdu_tready,
    input  logic [REG_ADDR_W-1:0]            mdu_address,
    input  logic [REGISTER_WIDTH-1:0]        mdu_data,
`ifdef REGWR_ARB_HAZARD_EN
    input  logic [REG_ADDR_W-1:0]            rs1_address,
    input  logic [REG_ADDR_W-1:0]            rs2_address,
    output logic                             rs1_pending,
    output logic                             rs2_pending,
`endif
    output logic                             rf_enable,
    output logic [REG_ADDR_W-1:0]            rf_address,
    output logic [REGISTER_WIDTH-1:0]        rf_data,
    output logic                             bubble_req,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]  pending_count
);

    localparam int               SC_W      = $clog2(STARVE_LIMIT + 1);
    localparam logic [SC_W-1:0]  SC_LIMIT  = SC_W'(STARVE_LIMIT);
    localparam logic [SC_W-1:0]  SC_ONE    = SC_W'(1);

    reg_write_t      mdu_entry_s;
    reg_write_t      head_entry_s;
    logic            head_live_s;
    logic            empty_s;
    logic            full_s;
    logic            push_s;
    logic            pop_s;
    logic            squash_en_s;
    logic [SC_W-1:0] starve_r;

    assign mdu_entry_s.address = mdu_address;
    assign mdu_entry_s.data    = mdu_data;

    // tready depends only on state (and reset), never on same-cycle inputs
    assign mdu_tready  = rst & ~full_s;
    // x0 results complete the handshake but are dropped
    assign push_s      = mdu_tvalid & mdu_tready & (mdu_address != {REG_ADDR_W{1'b0}});
    assign pop_s       = rst & ~wb_enable & ~empty_s;
    assign squash_en_s = wb_enable & (wb_address != {REG_ADDR_W{1'b0}});
    assign bubble_req  = (starve_r == SC_LIMIT);

    regwr_pending_fifo #(
        .FIFO_DEPTH     (FIFO_DEPTH)
    ) u_pending_fifo (
        .clk            (clk),
        .rst            (rst),
        .push           (push_s),
        .push_entry     (mdu_entry_s),
        .pop            (pop_s),
        .squash_en      (squash_en_s),
        .squash_address (wb_address),
`ifdef REGWR_ARB_HAZARD_EN
        .rs1_address    (rs1_address),
        .rs2_address    (rs2_address),
        .rs1_hit        (rs1_pending),
        .rs2_hit        (rs2_pending),
`endif
        .head_entry     (head_entry_s),
        .head_live      (head_live_s),
        .empty          (empty_s),
        .full           (full_s),
        .count          (pending_count)
    );

    // write-port mux: writeback first, then live FIFO head; squashed heads pop silently
    always_comb begin
        rf_enable  = 1'b0;
        rf_address = {REG_ADDR_W{1'b0}};
        rf_data    = {REGISTER_WIDTH{1'b0}};
        if (!rst) begin
            rf_enable = 1'b0;
        end else if (wb_enable) begin
            rf_enable  = 1'b1;
            rf_address = wb_address;
            rf_data    = wb_data;
        end else if (!empty_s && head_live_s) begin
            rf_enable  = 1'b1;
            rf_address = head_entry_s.address;
            rf_data    = head_entry_s.data;
        end else begin
            rf_enable = 1'b0;
        end
    end

    // starvation counter: blocked cycles of a non-empty FIFO, saturating, cleared by a pop
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            starve_r <= {SC_W{1'b0}};
        end else if (pop_s) begin
            starve_r <= {SC_W{1'b0}};
        end else if (!empty_s && wb_enable && (starve_r != SC_LIMIT)) begin
            starve_r <= starve_r + SC_ONE;
        end else begin
            starve_r <= starve_r;
        end
    end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
module tb_regfile_write_arbiter;
    import regfile_write_arbiter_pkg::*;

    logic                      clk;
    logic                      rst;
    logic                      wb_enable;
    logic [REG_ADDR_W-1:0]     wb_address;
    logic [REGISTER_WIDTH-1:0] wb_data;
    logic                      mdu_tvalid;
    logic                      mdu_tready;
    logic [REG_ADDR_W-1:0]     mdu_address;
    logic [REGISTER_WIDTH-1:0] mdu_data;
    logic                      rf_enable;
    logic [REG_ADDR_W-1:0]     rf_address;
    logic [REGISTER_WIDTH-1:0] rf_data;
    logic                      bubble_req;
    logic [2:0]                pending_count;
`ifdef REGWR_ARB_HAZARD_EN
    logic [REG_ADDR_W-1:0]     rs1_address;
    logic [REG_ADDR_W-1:0]     rs2_address;
    logic                      rs1_pending;
    logic                      rs2_pending;
`endif

    int tests_run;
    int tests_failed;

    regfile_write_arbiter #(
        .FIFO_DEPTH    (4),
        .STARVE_LIMIT  (8)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .wb_enable     (wb_enable),
        .wb_address    (wb_address),
        .wb_data       (wb_data),
        .mdu_tvalid    (mdu_tvalid),
        .mdu_tready    (mdu_tready),
        .mdu_address   (mdu_address),
        .mdu_data      (mdu_data),
`ifdef REGWR_ARB_HAZARD_EN
        .rs1_address   (rs1_address),
        .rs2_address   (rs2_address),
        .rs1_pending   (rs1_pending),
        .rs2_pending   (rs2_pending),
`endif
        .rf_enable     (rf_enable),
        .rf_address    (rf_address),
        .rf_data       (rf_data),
        .bubble_req    (bubble_req),
        .pending_count (pending_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        tests_run++;
        assert (observed === expected) else begin
            tests_failed++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    // advance to just after the next rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_wb(input logic en, input logic [4:0] a, input logic [31:0] d);
        wb_enable  = en;
        wb_address = a;
        wb_data    = d;
    endtask

    task automatic set_mdu(input logic v, input logic [4:0] a, input logic [31:0] d);
        mdu_tvalid  = v;
        mdu_address = a;
        mdu_data    = d;
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rst = 1'b0;
        set_wb(1'b1, 5'd4, 32'h0000_0044);
        set_mdu(1'b0, 5'd0, 32'h0);
`ifdef REGWR_ARB_HAZARD_EN
        rs1_address = 5'd0;
        rs2_address = 5'd0;
`endif
        // reset state, writeback request present but gated
        #2;
        chk("rst_count",     32'(pending_count), 32'd0);
        chk("rst_rf_enable", 32'(rf_enable),     32'd0);
        chk("rst_rf_addr",   32'(rf_address),    32'd0);
        chk("rst_tready",    32'(mdu_tready),    32'd0);
        chk("rst_bubble",    32'(bubble_req),    32'd0);
        tick();
        rst = 1'b1;
        set_wb(1'b0, 5'd0, 32'h0);
        tick();

        // 1: single MDU push x5=0xA, written the following cycle
        set_mdu(1'b1, 5'd5, 32'h0000_000A);
        #1;
        chk("t1_tready",  32'(mdu_tready), 32'd1);
        chk("t1_rf_idle", 32'(rf_enable),  32'd0);
        tick();
        set_mdu(1'b0, 5'd0, 32'h0);
        #1;
        chk("t1_count",   32'(pending_count), 32'd1);
        chk("t1_rf_en",   32'(rf_enable),     32'd1);
        chk("t1_rf_addr", 32'(rf_address),    32'd5);
        chk("t1_rf_data", rf_data,            32'h0000_000A);
        tick();
        #1;
        chk("t1_drained", 32'(pending_count), 32'd0);
        chk("t1_rf_off",  32'(rf_enable),     32'd0);

        // 2: fill under continuous writeback, then drain in order
        set_wb(1'b1, 5'd1, 32'h0000_0100);
        for (int i = 0; i < 4; i++) begin
            set_mdu(1'b1, 5'(10 + i), 32'(32'hB0 + i));
            #1;
            chk("t2_wb_wins", 32'(rf_address), 32'd1);
            tick();
        end
        set_mdu(1'b0, 5'd0, 32'h0);
        #1;
        chk("t2_full_count",  32'(pending_count), 32'd4);
        chk("t2_full_tready", 32'(mdu_tready),    32'd0);
        tick();
        set_wb(1'b0, 5'd0, 32'h0);
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("t2_drain_count", 32'(pending_count), 32'(4 - i));
            chk("t2_drain_tready", 32'(mdu_tready), (i == 0) ? 32'd0 : 32'd1);
            chk("t2_drain_en",    32'(rf_enable),  32'd1);
            chk("t2_drain_addr",  32'(rf_address), 32'(10 + i));
            chk("t2_drain_data",  rf_data,         32'(32'hB0 + i));
            tick();
        end
        #1;
        chk("t2_empty", 32'(pending_count), 32'd0);

        // 3: WAW squash of a queued entry
        set_mdu(1'b1, 5'd7, 32'h0000_0011);
        tick();
        set_mdu(1'b0, 5'd0, 32'h0);
        set_wb(1'b1, 5'd7, 32'h0000_0022);
        #1;
        chk("t3_wb_data",  rf_data,            32'h0000_0022);
        chk("t3_count1",   32'(pending_count), 32'd1);
        tick();
        set_wb(1'b0, 5'd0, 32'h0);
        #1;
        chk("t3_squash_en", 32'(rf_enable),     32'd0);
        chk("t3_count1b",   32'(pending_count), 32'd1);
        tick();
        #1;
        chk("t3_count0",    32'(pending_count), 32'd0);
        // same-cycle push and writeback to x7
        set_wb(1'b1, 5'd7, 32'h0000_0033);
        set_mdu(1'b1, 5'd7, 32'h0000_0044);
        #1;
        chk("t3_same_data", rf_data, 32'h0000_0033);
        tick();
        set_wb(1'b0, 5'd0, 32'h0);
        set_mdu(1'b0, 5'd0, 32'h0);
        #1;
        chk("t3_same_count", 32'(pending_count), 32'd1);
        chk("t3_same_en",    32'(rf_enable),     32'd0);
        tick();
        #1;
        chk("t3_same_count0", 32'(pending_count), 32'd0);

        // 4: starvation -> bubble_req after 8 blocked cycles
        set_wb(1'b1, 5'd2, 32'h0000_0200);
        set_mdu(1'b1, 5'd9, 32'h0000_0099);
        tick();
        set_mdu(1'b0, 5'd0, 32'h0);
        for (int i = 0; i < 8; i++) begin
            #1;
            chk("t4_no_bubble", 32'(bubble_req), 32'd0);
            tick();
        end
        set_wb(1'b0, 5'd0, 32'h0);
        #1;
        chk("t4_bubble",  32'(bubble_req), 32'd1);
        chk("t4_pop_en",  32'(rf_enable),  32'd1);
        chk("t4_pop_addr", 32'(rf_address), 32'd9);
        chk("t4_pop_data", rf_data,         32'h0000_0099);
        tick();
        #1;
        chk("t4_bubble_off", 32'(bubble_req),    32'd0);
        chk("t4_count0",     32'(pending_count), 32'd0);

`ifdef REGWR_ARB_HAZARD_EN
        // 6: hazard lookup on queued x3
        set_wb(1'b1, 5'd1, 32'h0000_0101);
        set_mdu(1'b1, 5'd3, 32'h0000_0333);
        tick();
        set_mdu(1'b0, 5'd0, 32'h0);
        rs1_address = 5'd3;
        rs2_address = 5'd4;
        #1;
        chk("t6_rs1_hit",  32'(rs1_pending), 32'd1);
        chk("t6_rs2_miss", 32'(rs2_pending), 32'd0);
        set_wb(1'b1, 5'd3, 32'h0000_0303);
        tick();
        #1;
        chk("t6_rs1_squashed", 32'(rs1_pending), 32'd0);
        set_wb(1'b0, 5'd0, 32'h0);
        rs1_address = 5'd0;
        rs2_address = 5'd0;
        tick();
        #1;
        chk("t6_count0", 32'(pending_count), 32'd0);
`endif

        // 5: x0 result is accepted but discarded
        set_mdu(1'b1, 5'd0, 32'h0000_00FF);
        #1;
        chk("t5_x0_tready", 32'(mdu_tready), 32'd1);
        tick();
        set_mdu(1'b0, 5'd0, 32'h0);
        #1;
        chk("t5_x0_count", 32'(pending_count), 32'd0);
        chk("t5_x0_rf",    32'(rf_enable),     32'd0);

        // 5: asynchronous reset with three queued entries
        set_wb(1'b1, 5'd1, 32'h0000_0111);
        for (int i = 0; i < 3; i++) begin
            set_mdu(1'b1, 5'(20 + i), 32'(32'hC0 + i));
            tick();
        end
        set_mdu(1'b0, 5'd0, 32'h0);
        #1;
        chk("t5_pre_count", 32'(pending_count), 32'd3);
        rst = 1'b0;
        #1;
        chk("t5_rst_count",  32'(pending_count), 32'd0);
        chk("t5_rst_rf",     32'(rf_enable),     32'd0);
        chk("t5_rst_tready", 32'(mdu_tready),    32'd0);
        tick();
        rst = 1'b1;
        set_wb(1'b0, 5'd0, 32'h0);
        #1;
        chk("t5_post_tready", 32'(mdu_tready),    32'd1);
        chk("t5_post_rf",     32'(rf_enable),     32'd0);
        tick();
        #1;
        chk("t5_post_count", 32'(pending_count), 32'd0);
        chk("t5_post_rf2",   32'(rf_enable),     32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
